// File: rtl/gpio_cmd_pkg.sv
// Shared definitions for the GPIO command scheduler: command word layout,
// opcodes, waveform register selects and the scheduler state encoding.
package gpio_cmd_pkg;

  localparam int OP_LSB  = 28;
  localparam int CH_LSB  = 24;
  localparam int PL_W    = 24;
  localparam int AMP_W   = 16;

  localparam logic [3:0] OP_NOP        = 4'h0;
  localparam logic [3:0] OP_STAGE_FREQ = 4'h1;
  localparam logic [3:0] OP_STAGE_AMP  = 4'h2;
  localparam logic [3:0] OP_COMMIT     = 4'h3;
  localparam logic [3:0] OP_STAGE_EN   = 4'h4;

  localparam logic [1:0] SEL_FREQ = 2'd0;
  localparam logic [1:0] SEL_AMP  = 2'd1;
  localparam logic [1:0] SEL_EN   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_APPLY     = 2'd2
  } sched_state_e;

  // Opcodes above STAGE_EN are reserved and treated as illegal.
  function automatic logic is_illegal_op(input logic [3:0] op);
    return op > OP_STAGE_EN;
  endfunction

endpackage

// File: rtl/cmd_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rdata always shows the head word.
// Pushes while full and pops while empty are ignored.
module cmd_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == FULL_CNT);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gpio_cmd_scheduler.sv
// Buffers waveform commands, stages register updates per channel and applies
// all dirty staging registers as a burst of writes on the next frame tick.
module gpio_cmd_scheduler
  import gpio_cmd_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DEPTH = 8,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           dst_clk,
  input  logic           dst_rst_n,
  input  logic           cmd_wen,
  input  logic [31:0]    cmd_wdata,
  input  logic           frame_tick,
  output logic           wr_en,
  output logic [CHW-1:0] wr_ch,
  output logic [1:0]     wr_sel,
  output logic [23:0]    wr_data,
  output logic           commit_done,
  output logic           busy,
  output logic           cmd_overflow,
  output logic [7:0]     err_cnt,
  output logic [1:0]     state_dbg
);

  // cmd_wen is a strobe with no ready: a word offered while the FIFO is full
  // is lost and latches cmd_overflow; wr_en has no back-pressure either.
  logic [31:0]             head;
  logic                    fifo_full, fifo_empty, pop;
  logic [$clog2(DEPTH):0]  fifo_count;

  cmd_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk   (dst_clk),
    .rst_n (dst_rst_n),
    .push  (cmd_wen),
    .wdata (cmd_wdata),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  sched_state_e state_q, state_d;

  logic [23:0]    freq_q [NCH];
  logic [15:0]    amp_q  [NCH];
  logic [NCH-1:0] en_q, fdirty_q, adirty_q;
  logic           edirty_q;
  logic           ovf_q;
  logic [7:0]     err_cnt_q;
  logic [CHW-1:0] wr_ch_q;
  logic [1:0]     wr_sel_q;
  logic [23:0]    wr_data_q;

  logic [3:0]     op;
  logic [CHW-1:0] ch_idx;
  logic           ch_ok, do_freq, do_amp, do_en, do_commit, do_err;

  assign op        = head[OP_LSB +: 4];
  assign ch_idx    = head[CH_LSB +: CHW];
  assign ch_ok     = int'(head[CH_LSB +: 4]) < NCH;
  assign do_freq   = pop && (op == OP_STAGE_FREQ) && ch_ok;
  assign do_amp    = pop && (op == OP_STAGE_AMP) && ch_ok;
  assign do_en     = pop && (op == OP_STAGE_EN);
  assign do_commit = pop && (op == OP_COMMIT);
  assign do_err    = pop && (is_illegal_op(op) ||
                     (((op == OP_STAGE_FREQ) || (op == OP_STAGE_AMP)) && !ch_ok));

  // Lowest dirty item wins: ch0 freq, ch0 amp, ch1 freq ... then the enable mask.
  logic           pick_any;
  logic [CHW-1:0] pick_ch;
  logic [1:0]     pick_sel;
  logic [23:0]    pick_data;

  always_comb begin
    pick_any  = edirty_q;
    pick_ch   = '0;
    pick_sel  = SEL_EN;
    pick_data = 24'(en_q);
    for (int c = NCH - 1; c >= 0; c--) begin
      if (adirty_q[c]) begin
        pick_any  = 1'b1;
        pick_ch   = CHW'(c);
        pick_sel  = SEL_AMP;
        pick_data = {8'h00, amp_q[c]};
      end
      if (fdirty_q[c]) begin
        pick_any  = 1'b1;
        pick_ch   = CHW'(c);
        pick_sel  = SEL_FREQ;
        pick_data = freq_q[c];
      end
    end
  end

  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (do_commit)  state_d = ST_WAIT_TICK;
      ST_WAIT_TICK: if (frame_tick) state_d = ST_APPLY;
      ST_APPLY:     if (!pick_any)  state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop         = (state_q == ST_IDLE) && !fifo_empty;
    wr_en       = (state_q == ST_APPLY) && pick_any;
    commit_done = (state_q == ST_APPLY) && !pick_any;
    wr_ch       = wr_en ? pick_ch   : wr_ch_q;
    wr_sel      = wr_en ? pick_sel  : wr_sel_q;
    wr_data     = wr_en ? pick_data : wr_data_q;
  end

  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        freq_q[c] <= '0;
        amp_q[c]  <= '0;
      end
      en_q      <= '0;
      fdirty_q  <= '0;
      adirty_q  <= '0;
      edirty_q  <= 1'b0;
      ovf_q     <= 1'b0;
      err_cnt_q <= '0;
      wr_ch_q   <= '0;
      wr_sel_q  <= '0;
      wr_data_q <= '0;
    end else begin
      if (do_freq) begin
        freq_q[ch_idx]   <= head[PL_W-1:0];
        fdirty_q[ch_idx] <= 1'b1;
      end
      if (do_amp) begin
        amp_q[ch_idx]    <= head[AMP_W-1:0];
        adirty_q[ch_idx] <= 1'b1;
      end
      if (do_en) begin
        en_q     <= head[NCH-1:0];
        edirty_q <= 1'b1;
      end
      if (wr_en) begin
        wr_ch_q   <= pick_ch;
        wr_sel_q  <= pick_sel;
        wr_data_q <= pick_data;
        if (pick_sel == SEL_EN)        edirty_q          <= 1'b0;
        else if (pick_sel == SEL_FREQ) fdirty_q[pick_ch] <= 1'b0;
        else                           adirty_q[pick_ch] <= 1'b0;
      end
      if (do_err && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      if (cmd_wen && fifo_full)           ovf_q     <= 1'b1;
    end
  end

  assign busy         = (state_q != ST_IDLE) || (fifo_count != '0);
  assign cmd_overflow = ovf_q;
  assign err_cnt      = err_cnt_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_gpio_cmd_scheduler.sv
// Directed bench for gpio_cmd_scheduler: expected writes and commit pulses,
// tagged with the cycle they must appear in, are matched by a monitor.
module tb_gpio_cmd_scheduler;

  localparam int NCH   = 4;
  localparam int DEPTH = 8;
  localparam int EW    = 63;

  logic        dst_clk = 1'b0;
  logic        dst_rst_n = 1'b0;
  logic        cmd_wen = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic        frame_tick = 1'b0;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [1:0]  wr_sel;
  logic [23:0] wr_data;
  logic        commit_done;
  logic        busy;
  logic        cmd_overflow;
  logic [7:0]  err_cnt;
  logic [1:0]  state_dbg;

  gpio_cmd_scheduler #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .dst_clk      (dst_clk),
    .dst_rst_n    (dst_rst_n),
    .cmd_wen      (cmd_wen),
    .cmd_wdata    (cmd_wdata),
    .frame_tick   (frame_tick),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_sel       (wr_sel),
    .wr_data      (wr_data),
    .commit_done  (commit_done),
    .busy         (busy),
    .cmd_overflow (cmd_overflow),
    .err_cnt      (err_cnt),
    .state_dbg    (state_dbg)
  );

  // clock / reset / cycle counter
  always #5 dst_clk = ~dst_clk;

  int cyc = 0;
  always @(posedge dst_clk) cyc <= cyc + 1;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_act;
  logic [EW-1:0] mon_exp;
  int checks = 0;
  int errors = 0;
  int t;

  function automatic logic [EW-1:0] ev_wr(input int tc, input int ch, input int sel,
                                          input logic [23:0] d);
    return {32'(tc), 1'b0, 4'(ch), 2'(sel), d};
  endfunction

  function automatic logic [EW-1:0] ev_done(input int tc);
    return {32'(tc), 1'b1, 30'd0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // driver tasks: each returns 1 ns after a rising edge
  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge dst_clk);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] ch, input logic [23:0] pl);
    cmd_wen   = 1'b1;
    cmd_wdata = {op, ch, pl};
    wait_cyc(1);
    cmd_wen   = 1'b0;
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    wait_cyc(1);
    frame_tick = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, 32'(wr_en), 0);
    check({tag, "_wr_ch"}, 32'(wr_ch), 0);
    check({tag, "_wr_sel"}, 32'(wr_sel), 0);
    check({tag, "_wr_data"}, 32'(wr_data), 0);
    check({tag, "_commit_done"}, 32'(commit_done), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_overflow"}, 32'(cmd_overflow), 0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 0);
    check({tag, "_state"}, 32'(state_dbg), 0);
  endtask

  // scoreboard monitor
  always @(negedge dst_clk) begin
    if (dst_rst_n && (wr_en || commit_done)) begin
      mon_act = commit_done ? {32'(cyc), 1'b1, 30'd0}
                            : {32'(cyc), 1'b0, 4'(wr_ch), wr_sel, wr_data};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL scoreboard actual=%h required=%h", mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    wait_cyc(3);
    check_all_zero("in_reset");
    dst_rst_n = 1'b1;
    wait_cyc(2);
    check_all_zero("after_reset");

    // freq + amp on ch1, write order and latency
    send(4'h1, 4'd1, 24'h123456);
    send(4'h2, 4'd1, 24'h00BEEF);
    send(4'h3, 4'd0, 24'h0);
    wait_cyc(4);
    check("wait_busy", 32'(busy), 1);
    check("wait_state", 32'(state_dbg), 1);
    t = cyc;
    exp_q.push_back(ev_wr(t + 1, 1, 0, 24'h123456));
    exp_q.push_back(ev_wr(t + 2, 1, 1, 24'h00BEEF));
    exp_q.push_back(ev_done(t + 3));
    do_tick();
    wait_cyc(5);
    check("hold_wr_data", 32'(wr_data), 32'h00BEEF);

    // re-staging overwrites and yields a single write
    send(4'h1, 4'd0, 24'h000010);
    send(4'h1, 4'd0, 24'h000020);
    send(4'h3, 4'd0, 24'h0);
    wait_cyc(4);
    t = cyc;
    exp_q.push_back(ev_wr(t + 1, 0, 0, 24'h000020));
    exp_q.push_back(ev_done(t + 2));
    do_tick();
    wait_cyc(4);

    // empty commit; tick during the COMMIT pop cycle is ignored
    send(4'h3, 4'd0, 24'h0);
    do_tick();
    wait_cyc(3);
    t = cyc;
    exp_q.push_back(ev_done(t + 1));
    do_tick();
    wait_cyc(3);
    check("idle_busy", 32'(busy), 0);

    // amp payload truncated to 16 bits; enable mask ignores the channel field
    send(4'h2, 4'd3, 24'hFF1234);
    send(4'h4, 4'd7, 24'h000005);
    send(4'h3, 4'd0, 24'h0);
    wait_cyc(4);
    t = cyc;
    exp_q.push_back(ev_wr(t + 1, 3, 1, 24'h001234));
    exp_q.push_back(ev_wr(t + 2, 0, 2, 24'h000005));
    exp_q.push_back(ev_done(t + 3));
    do_tick();
    wait_cyc(4);
    check("no_err_yet", 32'(err_cnt), 0);

    // illegal commands count and saturate
    send(4'h7, 4'd0, 24'h0);
    send(4'h7, 4'd0, 24'h0);
    send(4'h7, 4'd0, 24'h0);
    send(4'h2, 4'd5, 24'h001111);
    wait_cyc(4);
    check("err_cnt_4", 32'(err_cnt), 4);
    for (int i = 0; i < 300; i++) send(4'h5 + 4'(i % 11), 4'd0, 24'h0);
    wait_cyc(4);
    check("err_cnt_sat", 32'(err_cnt), 255);
    check("no_overflow", 32'(cmd_overflow), 0);

    // 9 words while WAIT_TICK: 8 stored, 9th dropped
    send(4'h3, 4'd0, 24'h0);
    wait_cyc(4);
    for (int c = 0; c < NCH; c++) send(4'h1, 4'(c), 24'h100000 + 24'(c));
    for (int c = 0; c < NCH; c++) send(4'h2, 4'(c), 24'h002000 + 24'(c));
    send(4'h4, 4'd0, 24'h00000F);
    wait_cyc(1);
    check("overflow_set", 32'(cmd_overflow), 1);
    check("full_busy", 32'(busy), 1);
    t = cyc;
    exp_q.push_back(ev_done(t + 1));
    do_tick();
    wait_cyc(14);
    send(4'h3, 4'd0, 24'h0);
    wait_cyc(4);
    t = cyc;
    for (int c = 0; c < NCH; c++) begin
      exp_q.push_back(ev_wr(t + 1 + 2 * c, c, 0, 24'h100000 + 24'(c)));
      exp_q.push_back(ev_wr(t + 2 + 2 * c, c, 1, 24'h002000 + 24'(c)));
    end
    exp_q.push_back(ev_done(t + 2 * NCH + 1));
    do_tick();
    wait_cyc(12);
    check("overflow_sticky", 32'(cmd_overflow), 1);

    // all items dirty, reset after the third write
    for (int c = 0; c < NCH; c++) send(4'h1, 4'(c), 24'h0A0000 + 24'(c));
    for (int c = 0; c < NCH; c++) send(4'h2, 4'(c), 24'h000B00 + 24'(c));
    send(4'h4, 4'd0, 24'h00000A);
    send(4'h3, 4'd0, 24'h0);
    wait_cyc(4);
    t = cyc;
    exp_q.push_back(ev_wr(t + 1, 0, 0, 24'h0A0000));
    exp_q.push_back(ev_wr(t + 2, 0, 1, 24'h000B00));
    exp_q.push_back(ev_wr(t + 3, 1, 0, 24'h0A0001));
    do_tick();
    wait_cyc(3);
    dst_rst_n = 1'b0;
    #1;
    check_all_zero("mid_apply_reset");
    wait_cyc(2);
    dst_rst_n = 1'b1;
    wait_cyc(2);
    check_all_zero("post_apply_reset");

    // staging dirty bits were cleared by reset
    send(4'h3, 4'd0, 24'h0);
    wait_cyc(4);
    t = cyc;
    exp_q.push_back(ev_done(t + 1));
    do_tick();
    wait_cyc(4);

    check("exp_q_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
